// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Holds the fetch PC and drives a ready-gated instruction-memory port.
// Fetched words go to decode through the IF/ID register (inst/dpc4/dvalid).
// Decode redirects (branch, jr, jump) take effect after one delay slot.
// When decode stalls, a one-entry hold buffer keeps the fetched word.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   pcsource          redirect select from decode (00 seq, 01 bpc, 10 ra, 11 jpc)
//   bpc, jpc, ra      redirect targets from decode
//   nostall           decode may consume the IF/ID instruction this cycle
//   imem_req/addr     fetch request and word address
//   imem_rdata/ready  fetch response
//   inst, dpc4        IF/ID instruction and its address + PC_INC
//   dvalid            IF/ID holds a real instruction
//   pc                current fetch PC (debug)
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | request outstanding at pc
// HOLD  | fetched word parked in hold buffer, waiting for decode
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic        dvalid_q, dvalid_d;
  logic [31:0] hold_q, hold_d;
  logic        redir_v_q, redir_v_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;

  logic        adv;
  logic        can_acc;
  logic        load;
  logic        redir;
  logic [31:0] word;
  logic [31:0] tgt;

  always_comb begin
    adv     = dvalid_q & nostall;
    can_acc = ~dvalid_q | nostall;
    redir   = adv & (pcsource != 2'b00);

    unique case (pcsource)
      2'b01:   tgt = bpc;
      2'b10:   tgt = ra;
      2'b11:   tgt = jpc;
      default: tgt = pc_q + PC_INC;
    endcase

    load = 1'b0;
    word = imem_rdata;
    if (state_q == S_FETCH) begin
      load = imem_ready & can_acc;
    end else if (state_q == S_HOLD) begin
      load = can_acc;
      word = hold_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    dpc4_d      = dpc4_q;
    dvalid_d    = dvalid_q;
    hold_d      = hold_q;
    redir_v_d   = redir_v_q;
    redir_tgt_d = redir_tgt_q;

    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready && !can_acc) begin
          hold_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD:  begin
        if (can_acc) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      inst_d    = word;
      dpc4_d    = pc_q + PC_INC;
      dvalid_d  = 1'b1;
      redir_v_d = 1'b0;
      if (redir)          pc_d = tgt;
      else if (redir_v_q) pc_d = redir_tgt_q;
      else                pc_d = pc_q + PC_INC;
    end else if (adv) begin
      // Decode drained its slot with nothing to replace it: insert a bubble.
      // A redirect seen now is parked until the delay slot is loaded.
      dvalid_d = 1'b0;
      inst_d   = NOP_INST;
      if (redir) begin
        redir_tgt_d = tgt;
        redir_v_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      dpc4_q      <= 32'd0;
      dvalid_q    <= 1'b0;
      hold_q      <= 32'd0;
      redir_v_q   <= 1'b0;
      redir_tgt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      dpc4_q      <= dpc4_d;
      dvalid_q    <= dvalid_d;
      hold_q      <= hold_d;
      redir_v_q   <= redir_v_d;
      redir_tgt_q <= redir_tgt_d;
    end
  end

  // A second redirect cannot arrive before the delay slot reaches decode.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(redir && redir_v_q));
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign dpc4      = dpc4_q;
  assign dvalid    = dvalid_q;
  assign pc        = pc_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined MIPS CPU. It is the producer side of the IF→ID interface.
- Holds the PC and drives a ready-gated instruction-memory port. Delivers inst/dpc4 to decode and applies the pcsource, bpc, jpc and jr-target redirects from decode, using one branch delay slot.
- Respects the decode stage's nostall back-pressure with a one-entry hold buffer.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (word address)
PC_INC, 32'd1, PC increment per instruction (PC is a word address, consistent with jpc/bpc)
NOP_INST, 32'h0000_0000, value of inst while IF/ID is empty or in reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pcsource  in  2  from decode: 00 seq, 01 bpc, 10 ra (jr), 11 jpc
bpc  in  32  branch target from decode
jpc  in  32  jump target from decode
ra  in  32  forwarded rs value from decode (jr target)
nostall  in  1  decode may consume the IF/ID instruction this cycle
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  completes the current request (may be high in the request's first cycle)
inst  out  32  IF/ID instruction
dpc4  out  32  IF/ID address of instruction + PC_INC
dvalid  out  1  IF/ID holds a real instruction
pc  out  32  current fetch PC (debug)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, inst=NOP_INST, dpc4=0, dvalid=0, imem_req=0, hold empty, redir_v=0, state IDLE. Reset mid-fetch abandons the request; the memory tolerates a dropped request.
- States and transitions:
  - IDLE → FETCH unconditionally, one cycle after reset.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0. The fetched word sits in the hold buffer. No new fetch starts while hold is occupied.
- Definitions:
  - adv = dvalid & nostall (decode consumes its instruction this cycle).
  - can_acc = ~dvalid | nostall.
- Load event L, where inst ← word, dpc4 ← fetch addr + PC_INC, dvalid ← 1:
  - In FETCH, when imem_ready & can_acc, with word = imem_rdata. State stays FETCH.
  - In HOLD, when can_acc, with word = hold. State → FETCH.
- FETCH with imem_ready & ~can_acc: hold ← imem_rdata, state → HOLD. pc does not advance yet.
- adv with no L in the same cycle: dvalid ← 0 and inst ← NOP_INST (bubble). ~nostall with dvalid=1: IF/ID is frozen.
- Redirect (delay slot):
  - Redirect condition: adv with pcsource≠00. Target T is bpc, ra or jpc per pcsource.
  - The instruction fetched after the branch (at pc) is the delay slot and always executes.
  - If L occurs in the same cycle as the redirect: pc ← T.
  - Otherwise: redir_tgt ← T, redir_v ← 1. On the next L: pc ← redir_tgt, redir_v ← 0.
- pc update: changes only on L. Next value is the same-cycle redirect target, else redir_tgt if redir_v, else pc+PC_INC.
- pcsource is ignored when adv=0.
- A second redirect while redir_v=1 cannot occur, because the delay slot is not yet in ID. This is an assertion only.
- Arithmetic: 32-bit, wrap-around modulo 2^32 with no error.
- Throughput: 1 instruction/cycle when imem_ready=1 continuously and nostall=1. Load-to-use latency from imem_ready to dvalid is one edge.

Test Plan:
1. rst high 2 cycles, then imem_ready=1, nostall=1 every cycle, mem[a]=0x1000+a → imem_addr 0,1,2…; inst 0x1000, 0x1001, 0x1002 on consecutive cycles; dpc4 1, 2, 3; dvalid=1 from 2nd post-reset edge.
2. imem_ready low for 3 cycles on addr 2 → imem_addr stays 2, imem_req=1; after the ID instruction leaves, dvalid=0 and inst=NOP; inst=0x1002 one edge after ready.
3. nostall=0 for 3 cycles while addr 3 completes → state HOLD, imem_req=0, inst frozen. On release, 0x1003 enters IF/ID and the next fetch address is 4.
4. Instruction at 4 in ID with pcsource=01, bpc=0x20, ready always 1 → delay slot 0x1005 (dpc4=6) delivered, then fetch addresses 0x20, 0x21.
5. pcsource=10, ra=0x40 at adv while the delay-slot fetch waits 2 cycles → redir_v set; delay slot delivered; next imem_addr=0x40; redir_v cleared.
6. rst asserted mid-wait in FETCH and in HOLD → next cycle dvalid=0, inst=NOP, imem_req=0, pc=RESET_PC; sequence of scenario 1 repeats.
